pwm_fade_ctrl: RTL and testbench
================================

Name: pwm_fade_ctrl

Overview:
Duty-cycle sequencer that sits directly upstream of the enhanced PWM core and drives its duty input. On a start command it ramps duty from a minimum to a maximum, holds, ramps back down and holds again, either once or looping. The result is hardware LED "breathing" or soft-start/soft-stop without CPU intervention. It is intended to sit in the same MMIO slot as the PWM core, with config and command fields written by the processor.

Parameters:
R, 10, PWM resolution; duty is R+1 bits, so 0..2^R maps to 0%..100%.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; begins a sequence when IDLE
stop  in  1  single-cycle pulse; aborts the sequence
loop_en  in  1  1 = repeat the up/down cycle until stop
duty_min  in  R+1  ramp floor
duty_max  in  R+1  ramp ceiling
step  in  R+1  duty increment per step; 0 is treated as 1
step_dvsr  in  32  clocks per step minus 1
hold_cycles  in  32  hold length in clocks minus 1
duty  out  R+1  registered duty, connects to the PWM core's duty input
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on normal (non-stop) completion
err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high; reset has priority over every other input.
- Reset values: state=IDLE, duty=0, busy=0, done=0, err=0, all counters=0, latched config=0.
- States: IDLE, UP, HOLD_HI, DOWN, HOLD_LO (enum).
- IDLE:
  - start=1 with duty_min<=duty_max: latch all config inputs. Next cycle: duty=min, state=UP, busy=1, step counter=0.
  - start=1 with duty_min>duty_max: err pulses next cycle; state stays IDLE; duty unchanged.
  - start and stop in the same cycle: stop wins; no action, no err.
- start while busy: ignored. Config inputs are sampled only at an accepted start; later changes have no effect until the next start.
- Step tick counter q:
  - Counts 0..step_dvsr in UP and DOWN.
  - Cleared to 0 on entry to UP or DOWN.
  - Tick when q==step_dvsr; q wraps to 0. A step occurs every step_dvsr+1 clocks, the first one step_dvsr+1 clocks after state entry.
- UP, on tick:
  - sum = duty+step, computed at R+2 bits (no overflow).
  - If sum>=max: duty=max and state=HOLD_HI. Otherwise duty=sum.
- DOWN, on tick:
  - If duty<=min+step (compared at R+2 bits): duty=min and state=HOLD_LO. Otherwise duty=duty-step.
- HOLD_HI / HOLD_LO:
  - The state lasts exactly hold_cycles+1 clocks; hold counter cleared on entry.
  - HOLD_HI exits to DOWN.
  - HOLD_LO exits to UP if loop_en was latched 1. Otherwise it goes to IDLE and done pulses in the first IDLE cycle, with busy=0 that same cycle.
- min==max: UP saturates on the first tick. The sequence still runs both holds and both ramps (each ramp one tick).
- stop in any non-IDLE state: next cycle state=IDLE, duty=latched min, busy=0, done not pulsed.
- Reset mid-sequence: all reset values apply next cycle; any pending done is lost.
- duty is registered and changes only on a step, on start, or on stop. The PWM core re-samples it every clock; glitch-free update on PWM period boundaries is not required.

Decomposition:
- Package pwm_fade_pkg:
  - fade_state_t enum.
  - Width constant helpers: DW=R+1 and the extended width R+2.
- One sub-module, fade_tick_gen: 32-bit prescale counter with clear and enable inputs and a tick output.
  - Instantiated once for step ticks.
  - The hold counter is inline.

Test Plan:
1. Single ramp. R=10, min=0, max=8, step=2, dvsr=3, hold=1, loop=0, start at c0.
   - Duty: 0@c1, 2@c5, 4@c9, 6@c13, 8@c17.
   - HOLD_HI c17–18; DOWN from c19.
   - Duty: 6@c23, 4@c27, 2@c31, 0@c35.
   - HOLD_LO c35–36; done=1 and busy=0 @c37.
2. Saturation/overflow. min=1000, max=1024, step=1024, dvsr=0, hold=0.
   - Up: duty 1000@c1, 1024@c2 (no wrap).
   - Down: reaches 1000 in one step.
3. Loop + stop. Scenario 1 config with loop=1: after HOLD_LO, state returns to UP and duty climbs again. stop pulse mid-UP → next cycle IDLE, duty=0, busy=0, no done.
4. Rejected start. min=20, max=10, start → err pulse, busy stays 0, duty unchanged.
5. step=0 and config change while busy:
   - step=0 behaves as step=1.
   - Rewriting max while busy does not change the ceiling.
   - start while busy is ignored, no err.
6. Reset mid-HOLD_HI → next cycle duty=0, IDLE, busy=0, done=0. A start followed by stop in the same cycle in IDLE produces no activity.

Source files
------------

// File: rtl/pwm_fade_pkg.sv
// Shared types and width helpers for the PWM fade sequencer.
package pwm_fade_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UP,
    HOLD_HI,
    DOWN,
    HOLD_LO
  } fade_state_t;

  localparam int unsigned R_DEFAULT = 10;

  // Duty width (R+1) and the widened width (R+2) used for overflow-free ramp math
  function automatic int unsigned duty_w(input int unsigned r);
    return r + 1;
  endfunction

  function automatic int unsigned ext_w(input int unsigned r);
    return r + 2;
  endfunction

endpackage

// File: rtl/fade_tick_gen.sv
// Prescale counter: pulses tick every dvsr+1 enabled clocks, restarts from 0 on clr.
module fade_tick_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] dvsr,
  output logic        tick
);

  logic [31:0] q;

  assign tick = en && (q == dvsr);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      if (q == dvsr) q <= '0;
      else           q <= q + 32'd1;
    end
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle sequencer: ramps PWM duty min->max, holds, ramps back, holds; once or looping.
module pwm_fade_ctrl
  import pwm_fade_pkg::*;
#(
  parameter int unsigned R = R_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  input  logic [R:0]  duty_min,
  input  logic [R:0]  duty_max,
  input  logic [R:0]  step,
  input  logic [31:0] step_dvsr,
  input  logic [31:0] hold_cycles,
  output logic [R:0]  duty,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned DW = duty_w(R);
  localparam int unsigned EW = ext_w(R);

  fade_state_t state, state_n;

  logic [DW-1:0] cfg_min, cfg_max, cfg_step;
  logic [31:0]   cfg_dvsr, cfg_hold;
  logic          cfg_loop;
  logic [31:0]   hold_cnt;

  logic          tick, ramp, hold_end, start_ok, start_bad, seq_done;
  logic [DW-1:0] step_eff;
  logic [EW-1:0] sum_x, floor_x, duty_x, max_x;

  assign ramp      = (state == UP) || (state == DOWN);
  assign hold_end  = (hold_cnt == cfg_hold);
  assign start_ok  = (state == IDLE) && start && !stop && (duty_min <= duty_max);
  assign start_bad = (state == IDLE) && start && !stop && (duty_min > duty_max);

  // A zero step would stall the ramp forever, so it is promoted to 1
  assign step_eff = (cfg_step == '0) ? DW'(1) : cfg_step;
  assign duty_x   = {1'b0, duty};
  assign max_x    = {1'b0, cfg_max};
  assign sum_x    = {1'b0, duty} + {1'b0, step_eff};
  assign floor_x  = {1'b0, cfg_min} + {1'b0, step_eff};

  fade_tick_gen u_step_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (!ramp),
    .en    (ramp),
    .dvsr  (cfg_dvsr),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_ok) state_n = UP;
      UP: begin
        if (stop)                          state_n = IDLE;
        else if (tick && (sum_x >= max_x)) state_n = HOLD_HI;
      end
      HOLD_HI: begin
        if (stop)          state_n = IDLE;
        else if (hold_end) state_n = DOWN;
      end
      DOWN: begin
        if (stop)                             state_n = IDLE;
        else if (tick && (duty_x <= floor_x)) state_n = HOLD_LO;
      end
      HOLD_LO: begin
        if (stop)          state_n = IDLE;
        else if (hold_end) state_n = cfg_loop ? UP : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    seq_done = (state == HOLD_LO) && hold_end && !cfg_loop && !stop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      duty     <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      hold_cnt <= '0;
      cfg_min  <= '0;
      cfg_max  <= '0;
      cfg_step <= '0;
      cfg_dvsr <= '0;
      cfg_hold <= '0;
      cfg_loop <= 1'b0;
    end else begin
      done <= seq_done;
      err  <= start_bad;

      // Counter restarts whenever a hold state is entered or left
      if (((state == HOLD_HI) || (state == HOLD_LO)) && (state_n == state))
        hold_cnt <= hold_cnt + 32'd1;
      else
        hold_cnt <= '0;

      if (start_ok) begin
        cfg_min  <= duty_min;
        cfg_max  <= duty_max;
        cfg_step <= step;
        cfg_dvsr <= step_dvsr;
        cfg_hold <= hold_cycles;
        cfg_loop <= loop_en;
        duty     <= duty_min;
      end else if ((state != IDLE) && stop) begin
        duty <= cfg_min;
      end else if (tick) begin
        if (state == UP)
          duty <= (sum_x >= max_x) ? cfg_max : sum_x[DW-1:0];
        else if (state == DOWN)
          duty <= (duty_x <= floor_x) ? cfg_min : duty - step_eff;
      end
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: table-driven ramp scenarios plus hand-written corner sequences.
module tb_pwm_fade_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop, loop_en;
  logic [10:0] duty_min, duty_max, step;
  logic [31:0] step_dvsr, hold_cycles;
  logic [10:0] duty;
  logic        busy, done, err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cur    = 0;

  typedef struct {
    logic [10:0] mn, mx, st;
    logic [31:0] dv, hd;
    logic        lp;
    int unsigned len;
  } cfg_t;

  typedef struct {
    int unsigned scen;
    int unsigned cyc;
    logic [10:0] duty;
    logic        busy;
    logic        done;
    logic        err;
  } vec_t;

  cfg_t cfgs[2];
  vec_t vecs[$];

  always #5 clk = ~clk;

  pwm_fade_ctrl #(.R(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
    .duty_min    (duty_min),
    .duty_max    (duty_max),
    .step        (step),
    .step_dvsr   (step_dvsr),
    .hold_cycles (hold_cycles),
    .duty        (duty),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [10:0] d, input logic b,
                         input logic dn, input logic e);
    chk({tag, "_duty"}, {21'd0, duty}, {21'd0, d});
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, "_done"}, {31'd0, done}, {31'd0, dn});
    chk({tag, "_err"},  {31'd0, err},  {31'd0, e});
  endtask

  // One clock: sample point is the falling edge; command pulses last one cycle
  task automatic adv();
    @(negedge clk);
    cur++;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic apply_cfg(input cfg_t c);
    duty_min    = c.mn;
    duty_max    = c.mx;
    step        = c.st;
    step_dvsr   = c.dv;
    hold_cycles = c.hd;
    loop_en     = c.lp;
  endtask

  task automatic run_scen(input int unsigned s);
    apply_cfg(cfgs[s]);
    cur   = 0;
    start = 1'b1;
    for (int unsigned c = 1; c <= cfgs[s].len; c++) begin
      adv();
      foreach (vecs[i])
        if (vecs[i].scen == s && vecs[i].cyc == c)
          chk_all($sformatf("s%0d_c%0d", s, c), vecs[i].duty, vecs[i].busy,
                  vecs[i].done, vecs[i].err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cfgs[0] = '{mn: 11'd0,    mx: 11'd8,    st: 11'd2,    dv: 32'd3, hd: 32'd1, lp: 1'b0, len: 38};
    cfgs[1] = '{mn: 11'd1000, mx: 11'd1024, st: 11'd1024, dv: 32'd0, hd: 32'd0, lp: 1'b0, len: 6};

    vecs.push_back('{0,  1, 11'd0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{0,  4, 11'd0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{0,  5, 11'd2, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{0,  9, 11'd4, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{0, 13, 11'd6, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{0, 17, 11'd8, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{0, 18, 11'd8, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{0, 22, 11'd8, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{0, 23, 11'd6, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{0, 27, 11'd4, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{0, 31, 11'd2, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{0, 35, 11'd0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{0, 36, 11'd0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{0, 37, 11'd0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{0, 38, 11'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1,  1, 11'd1000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1,  2, 11'd1024, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1,  3, 11'd1024, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1,  4, 11'd1000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1,  5, 11'd1000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1,  6, 11'd1000, 1'b0, 1'b0, 1'b0});

    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    apply_cfg(cfgs[0]);
    repeat (3) @(negedge clk);
    chk_all("reset", 11'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Single ramp and saturation scenarios
    run_scen(0);
    run_scen(1);

    // Loop mode returns to UP after HOLD_LO, then stop aborts mid-ramp
    apply_cfg(cfgs[0]);
    loop_en = 1'b1;
    cur = 0;
    start = 1'b1;
    while (cur < 36) adv();
    chk_all("loop_c36", 11'd0, 1'b1, 1'b0, 1'b0);
    adv();
    chk_all("loop_c37", 11'd0, 1'b1, 1'b0, 1'b0);
    while (cur < 41) adv();
    chk_all("loop_c41", 11'd2, 1'b1, 1'b0, 1'b0);
    adv();
    stop = 1'b1;
    adv();
    chk_all("loop_stop", 11'd0, 1'b0, 1'b0, 1'b0);
    adv();
    chk_all("loop_after", 11'd0, 1'b0, 1'b0, 1'b0);

    // Stop restores the latched floor, not zero
    duty_min = 11'd5; duty_max = 11'd9; step = 11'd1;
    step_dvsr = 32'd0; hold_cycles = 32'd3; loop_en = 1'b0;
    cur = 0;
    start = 1'b1;
    adv();
    chk_all("floor_c1", 11'd5, 1'b1, 1'b0, 1'b0);
    adv();
    chk_all("floor_c2", 11'd6, 1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    adv();
    chk_all("floor_stop", 11'd5, 1'b0, 1'b0, 1'b0);

    // min > max is rejected with an err pulse
    duty_min = 11'd20; duty_max = 11'd10;
    start = 1'b1;
    adv();
    chk_all("rej_c1", 11'd5, 1'b0, 1'b0, 1'b1);
    adv();
    chk_all("rej_c2", 11'd5, 1'b0, 1'b0, 1'b0);

    // step=0 acts as 1; max rewrite and restart while busy have no effect
    duty_min = 11'd0; duty_max = 11'd3; step = 11'd0;
    step_dvsr = 32'd1; hold_cycles = 32'd0;
    cur = 0;
    start = 1'b1;
    adv();
    chk_all("s0_c1", 11'd0, 1'b1, 1'b0, 1'b0);
    adv();
    duty_max = 11'd1000;
    adv();
    chk_all("s0_c3", 11'd1, 1'b1, 1'b0, 1'b0);
    start = 1'b1;
    adv();
    chk_all("s0_c4", 11'd1, 1'b1, 1'b0, 1'b0);
    adv();
    chk_all("s0_c5", 11'd2, 1'b1, 1'b0, 1'b0);
    adv(); adv();
    chk_all("s0_c7", 11'd3, 1'b1, 1'b0, 1'b0);
    adv();
    chk_all("s0_c8", 11'd3, 1'b1, 1'b0, 1'b0);
    adv(); adv();
    chk_all("s0_c10", 11'd2, 1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    adv();

    // Reset in HOLD_HI, then simultaneous start+stop in IDLE
    apply_cfg(cfgs[0]);
    cur = 0;
    start = 1'b1;
    while (cur < 18) adv();
    chk_all("rst_c18", 11'd8, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    adv();
    reset = 1'b0;
    chk_all("rst_c19", 11'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    stop  = 1'b1;
    adv();
    chk_all("ss_c1", 11'd0, 1'b0, 1'b0, 1'b0);
    adv();
    chk_all("ss_c2", 11'd0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
